regfile_mp_sb: RTL and testbench



---
 rtl/regfile_mp_sb.sv | 102 ++++++++++
 tb/tb_regfile_mp_sb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-read-port integer register file with clear sequencer, bypass and busy scoreboard
module regfile_mp_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrtEn,
  input  logic [AW-1:0]       wrtReg,
  input  logic [XLEN-1:0]     wrtData,
  input  logic                rsvEn,
  input  logic [AW-1:0]       rsvReg,
  input  logic [NRD*AW-1:0]   rdReg,
  output logic [NRD*XLEN-1:0] rdData,
  output logic [NRD-1:0]      rdBusy,
  output logic                ready
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_clr_idx;
  logic              r_ready;
  logic [XLEN-1:0]   r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  logic              w_run;
  logic [NREG-1:0]   w_busy_clr;
  logic [NREG-1:0]   w_busy_set;

  assign w_run = (r_state == ST_RUN);
  assign ready = r_ready;

  // Clear sweep sequencer: one entry per cycle, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + AW'(1);
      if (r_clr_idx == AW'(NREG - 1)) begin
        r_state <= ST_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // Storage: the sweep owns the write path while clearing; x0 writes are dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_regs[r_clr_idx] <= '0;
      end else if (wrtEn && (wrtReg != '0)) begin
        r_regs[wrtReg] <= wrtData;
      end
    end
  end

  // Scoreboard update masks; set is applied after clear so a new reservation wins
  always_comb begin
    w_busy_clr = '0;
    w_busy_set = '0;
    if (w_run) begin
      if (wrtEn) w_busy_clr[wrtReg] = 1'b1;
      if (rsvEn) w_busy_set[rsvReg] = 1'b1;
    end
    w_busy_set[0] = 1'b0;
  end

  // Busy bits: cleared on reset, updated only in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
    end
  end

  // Read ports: zero while clearing or for x0, optional same-cycle forwarding of the write port
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    logic          w_zero;

    assign w_addr = rdReg[g*AW +: AW];
    assign w_zero = !w_run || (w_addr == '0);
    assign w_hit  = (BYPASS != 0) && w_run && wrtEn && (wrtReg == w_addr);

    assign rdData[g*XLEN +: XLEN] = w_zero ? '0 :
                                    w_hit  ? wrtData :
                                             r_regs[w_addr];
    assign rdBusy[g] = !w_zero && !w_hit && r_busy[w_addr];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - self-checking bench for regfile_mp_sb (default and 64-bit/16-reg/3-port no-bypass builds)
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: XLEN=32, NREG=32, NRD=2, BYPASS=1
  logic         a_rst, a_wen, a_ren, a_ready;
  logic [4:0]   a_wreg, a_rreg;
  logic [31:0]  a_wdata;
  logic [9:0]   a_rdreg;
  logic [63:0]  a_rddata;
  logic [1:0]   a_rdbusy;

  // Instance B: XLEN=64, NREG=16, NRD=3, BYPASS=0
  logic         b_rst, b_wen, b_ren, b_ready;
  logic [3:0]   b_wreg, b_rreg;
  logic [63:0]  b_wdata;
  logic [11:0]  b_rdreg;
  logic [191:0] b_rddata;
  logic [2:0]   b_rdbusy;

  regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(a_rst), .wrtEn(a_wen), .wrtReg(a_wreg), .wrtData(a_wdata),
    .rsvEn(a_ren), .rsvReg(a_rreg), .rdReg(a_rdreg), .rdData(a_rddata),
    .rdBusy(a_rdbusy), .ready(a_ready)
  );

  regfile_mp_sb #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst(b_rst), .wrtEn(b_wen), .wrtReg(b_wreg), .wrtData(b_wdata),
    .rsvEn(b_ren), .rsvReg(b_rreg), .rdReg(b_rdreg), .rdData(b_rddata),
    .rdBusy(b_rdbusy), .ready(b_ready)
  );

  // Reference model: contents, busy flags and cycles elapsed since reset release
  logic [31:0] ma [32];
  logic        ba [32];
  int          ca = 0;
  logic [63:0] mb [16];
  logic        bb [16];
  int          cb = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        ren;
    logic [4:0]  rreg;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic update_models();
    if (a_rst) begin
      ca = 0;
      for (int k = 0; k < 32; k++) begin ma[k] = '0; ba[k] = 1'b0; end
    end else if (ca < 32) begin
      ca++;
    end else begin
      if (a_wen && a_wreg != 0) ma[a_wreg] = a_wdata;
      if (a_wen) ba[a_wreg] = 1'b0;
      if (a_ren) ba[a_rreg] = 1'b1;
      ba[0] = 1'b0;
    end
    if (b_rst) begin
      cb = 0;
      for (int k = 0; k < 16; k++) begin mb[k] = '0; bb[k] = 1'b0; end
    end else if (cb < 16) begin
      cb++;
    end else begin
      if (b_wen && b_wreg != 0) mb[b_wreg] = b_wdata;
      if (b_wen) bb[b_wreg] = 1'b0;
      if (b_ren) bb[b_rreg] = 1'b1;
      bb[0] = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [4:0]  ra;
    logic [3:0]  rb;
    logic [63:0] ed;
    logic        eb;
    chk("a_ready", 64'(a_ready), (ca >= 32) ? 64'd1 : 64'd0);
    for (int i = 0; i < 2; i++) begin
      ra = a_rdreg[i*5 +: 5];
      if (ca < 32 || ra == 0) begin ed = '0; eb = 1'b0; end
      else if (a_wen && a_wreg == ra) begin ed = 64'(a_wdata); eb = 1'b0; end
      else begin ed = 64'(ma[ra]); eb = ba[ra]; end
      chk($sformatf("a_rddata%0d", i), 64'(a_rddata[i*32 +: 32]), ed);
      chk($sformatf("a_rdbusy%0d", i), 64'(a_rdbusy[i]), 64'(eb));
    end
    chk("b_ready", 64'(b_ready), (cb >= 16) ? 64'd1 : 64'd0);
    for (int i = 0; i < 3; i++) begin
      rb = b_rdreg[i*4 +: 4];
      if (cb < 16 || rb == 0) begin ed = '0; eb = 1'b0; end
      else begin ed = mb[rb]; eb = bb[rb]; end
      chk($sformatf("b_rddata%0d", i), b_rddata[i*64 +: 64], ed);
      chk($sformatf("b_rdbusy%0d", i), 64'(b_rdbusy[i]), 64'(eb));
    end
  endtask

  task automatic half_end();
    compare_all();
    @(posedge clk);
    update_models();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    half_end();
  endtask

  task automatic idle_inputs();
    a_wen = 0; a_wreg = '0; a_wdata = '0; a_ren = 0; a_rreg = '0; a_rdreg = '0;
    b_wen = 0; b_wreg = '0; b_wdata = '0; b_ren = 0; b_rreg = '0; b_rdreg = '0;
  endtask

  initial begin
    int ra_cyc;
    int rb_cyc;
    logic [63:0] v3, v9, v14;

    tbl[0]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'h12345678, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd5, 5'd7, 32'h12345678, 32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'h12345678, 32'h0,        1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5'd7, 32'hA5,       1'b0, 5'd0, 5'd5, 5'd7, 32'h12345678, 32'hA5,       1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'h12345678, 32'hA5,       1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h1,        1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h1,        1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h1,        32'h1,        1'b1, 1'b1};
    tbl[11] = '{1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 5'd9, 5'd7, 32'h55,       32'h1,        1'b0, 1'b1};
    tbl[12] = '{1'b1, 5'd7, 32'h2,        1'b1, 5'd9, 5'd9, 5'd7, 32'h55,       32'h2,        1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd7, 32'h55,       32'h2,        1'b1, 1'b0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h55,       1'b0, 1'b1};
    tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h55,       1'b0, 1'b1};

    // Reset both instances for one cycle
    idle_inputs();
    a_rst = 1; b_rst = 1;
    @(posedge clk);
    update_models();
    #1;
    a_rst = 0; b_rst = 0;

    // Clear sweep: measure ready latency while hammering writes/reservations that must be ignored
    ra_cyc = -1;
    rb_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      a_wen = (c < 20); a_wreg = 5'd5; a_wdata = 32'hCAFEF00D; a_ren = (c < 20); a_rreg = 5'd6;
      a_rdreg = {5'd6, 5'd5};
      b_wen = (c < 10); b_wreg = 4'd5; b_wdata = 64'hFEEDFACE_01234567; b_ren = (c < 10); b_rreg = 4'd6;
      b_rdreg = {4'd7, 4'd6, 4'd5};
      @(negedge clk);
      if (c == 0) begin
        chk("reset_a_ready", 64'(a_ready), 64'd0);
        chk("reset_a_rddata", a_rddata, 64'd0);
        chk("reset_a_rdbusy", 64'(a_rdbusy), 64'd0);
      end
      if (a_ready && ra_cyc < 0) ra_cyc = c;
      if (b_ready && rb_cyc < 0) rb_cyc = c;
      half_end();
    end
    chk("a_ready_latency", 64'(ra_cyc), 64'd32);
    chk("b_ready_latency", 64'(rb_cyc), 64'd16);

    // Every register reads zero after the sweep
    idle_inputs();
    for (int r = 0; r < 32; r++) begin
      a_rdreg = {5'(31 - r), 5'(r)};
      b_rdreg = {4'(r + 2), 4'(r + 1), 4'(r)};
      @(negedge clk);
      chk($sformatf("clr_zero_a%0d", r), a_rddata, 64'd0);
      chk($sformatf("clr_busy_a%0d", r), 64'(a_rdbusy), 64'd0);
      half_end();
    end

    // Directed vectors on instance A: x0, bypass, scoreboard set/clear interactions
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      a_wen = tbl[k].wen; a_wreg = tbl[k].wreg; a_wdata = tbl[k].wdata;
      a_ren = tbl[k].ren; a_rreg = tbl[k].rreg;
      a_rdreg = {tbl[k].r1, tbl[k].r0};
      @(negedge clk);
      chk($sformatf("tbl%0d_d0", k), 64'(a_rddata[31:0]), 64'(tbl[k].d0));
      chk($sformatf("tbl%0d_d1", k), 64'(a_rddata[63:32]), 64'(tbl[k].d1));
      chk($sformatf("tbl%0d_b0", k), 64'(a_rdbusy[0]), 64'(tbl[k].b0));
      chk($sformatf("tbl%0d_b1", k), 64'(a_rdbusy[1]), 64'(tbl[k].b1));
      half_end();
    end

    // Instance B without bypass: old value in the write cycle, new value after
    idle_inputs();
    b_wen = 1; b_wreg = 4'd5; b_wdata = 64'h12345678; b_rdreg = {4'd0, 4'd0, 4'd5};
    @(negedge clk);
    chk("b_nobypass_old", b_rddata[63:0], 64'd0);
    half_end();
    b_wen = 0;
    @(negedge clk);
    chk("b_nobypass_new", b_rddata[63:0], 64'h12345678);
    half_end();

    // Instance B: three ports read three distinct 64-bit registers in one cycle
    v3  = {$urandom, $urandom};
    v9  = {$urandom, $urandom};
    v14 = {$urandom, $urandom};
    b_wen = 1; b_wreg = 4'd3;  b_wdata = v3;  tick();
    b_wen = 1; b_wreg = 4'd9;  b_wdata = v9;  tick();
    b_wen = 1; b_wreg = 4'd14; b_wdata = v14; tick();
    b_wen = 0; b_rdreg = {4'd14, 4'd9, 4'd3};
    @(negedge clk);
    chk("b_port0_r3", b_rddata[63:0], v3);
    chk("b_port1_r9", b_rddata[127:64], v9);
    chk("b_port2_r14", b_rddata[191:128], v14);
    half_end();

    // Mid-operation reset on A: writes in flight, reg3 reserved, reset asserted mid-stream
    idle_inputs();
    for (int r = 1; r <= 24; r++) begin
      a_wen = 1; a_wreg = 5'(r); a_wdata = $urandom;
      a_ren = (r == 5); a_rreg = 5'd3;
      a_rdreg = {5'd3, 5'(r)};
      a_rst = (r == 20);
      @(negedge clk);
      if (r == 21) begin
        chk("midrst_ready", 64'(a_ready), 64'd0);
        chk("midrst_busy", 64'(a_rdbusy), 64'd0);
      end
      half_end();
    end
    a_rst = 0;
    idle_inputs();
    for (int c = 0; c < 30; c++) tick();
    for (int r = 0; r < 32; r++) begin
      a_rdreg = {5'd3, 5'(r)};
      @(negedge clk);
      chk($sformatf("midrst_zero%0d", r), 64'(a_rddata[31:0]), 64'd0);
      chk($sformatf("midrst_b3_%0d", r), 64'(a_rdbusy[1]), 64'd0);
      half_end();
    end

    // Randomized traffic on both instances against the reference model
    for (int n = 0; n < 3000; n++) begin
      a_rst = ($urandom_range(0, 599) == 0);
      a_wen = 1'($urandom_range(0, 1)); a_wreg = 5'($urandom); a_wdata = $urandom;
      a_ren = ($urandom_range(0, 2) == 0); a_rreg = 5'($urandom);
      a_rdreg = 10'($urandom);
      if ($urandom_range(0, 3) == 0) a_rdreg[4:0] = a_wreg;
      if ($urandom_range(0, 3) == 0) a_rdreg[9:5] = a_rreg;
      b_rst = ($urandom_range(0, 599) == 0);
      b_wen = 1'($urandom_range(0, 1)); b_wreg = 4'($urandom); b_wdata = {$urandom, $urandom};
      b_ren = ($urandom_range(0, 2) == 0); b_rreg = 4'($urandom);
      b_rdreg = 12'($urandom);
      if ($urandom_range(0, 3) == 0) b_rdreg[3:0] = b_wreg;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
